// File: rtl/key_event_classifier.sv
// Turns debounced press/release edge pulses into short/double/long/auto-repeat
// event pulses. All timing runs off a 1 ms tick from an internal prescaler.
module key_event_classifier #(
    parameter int FREQ      = 50,
    parameter int LONG_MS   = 1000,
    parameter int DBL_MS    = 250,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_press,
    input  logic key_release,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic auto_repeat,
    output logic busy
);

    localparam int PRE_CNT = FREQ * 1000;
    localparam int PRE_W   = $clog2(PRE_CNT);
    localparam int MS_MAX  = (LONG_MS > DBL_MS) ?
                             ((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS) :
                             ((DBL_MS > REPEAT_MS) ? DBL_MS : REPEAT_MS);
    localparam int MS_W    = $clog2(MS_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PRE_CNT - 1);
    localparam logic [MS_W-1:0]  LONG_T = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0]  DBL_T  = MS_W'(DBL_MS);
    localparam logic [MS_W-1:0]  REP_T  = MS_W'(REPEAT_MS);

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

    state_t           state;
    logic [PRE_W-1:0] presc;
    logic [MS_W-1:0]  ms;
    logic             press, rel;
    logic             ms_long, ms_dbl, ms_rep;
    logic             timer_clr;

    // Simultaneous press and release cancel each other out.
    assign press   = key_press & ~key_release;
    assign rel     = key_release & ~key_press;
    assign ms_long = (ms == LONG_T);
    assign ms_dbl  = (ms == DBL_T);
    assign ms_rep  = (ms == REP_T);

    // Timer restarts on any state change and on each repeat emission.
    always_comb begin
        timer_clr = 1'b0;
        case (state)
            IDLE:    timer_clr = press;
            PRESS1:  timer_clr = rel | ms_long;
            WAIT2:   timer_clr = press | ms_dbl;
            PRESS2:  timer_clr = rel;
            HOLD:    timer_clr = rel | ms_rep;
            default: timer_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            ms    <= '0;
        end else if (timer_clr) begin
            presc <= '0;
            ms    <= '0;
        end else if (presc == PRE_TC) begin
            presc <= '0;
            if (!(&ms))
                ms <= ms + MS_W'(1);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            auto_repeat  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            auto_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state <= PRESS1;
                        busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (rel) begin
                        state <= WAIT2;
                    end else if (ms_long) begin
                        state      <= HOLD;
                        long_press <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (press) begin
                        state <= PRESS2;
                    end else if (ms_dbl) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                PRESS2: begin
                    if (rel) begin
                        state        <= IDLE;
                        double_click <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                HOLD: begin
                    if (rel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ms_rep) begin
                        auto_repeat <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench: expected pulses (kind + cycle) are queued as stimulus is driven
// and matched against every pulse the DUT emits.
module tb_key_event_classifier;

    localparam int FREQ      = 1;
    localparam int LONG_MS   = 10;
    localparam int DBL_MS    = 4;
    localparam int REPEAT_MS = 3;
    localparam int P         = FREQ * 1000;
    localparam int R_GAP     = REPEAT_MS * P + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_press = 1'b0;
    logic key_release = 1'b0;
    logic short_press, double_click, long_press, auto_repeat, busy;

    key_event_classifier #(
        .FREQ(FREQ), .LONG_MS(LONG_MS), .DBL_MS(DBL_MS), .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk(clk), .rst(rst),
        .key_press(key_press), .key_release(key_release),
        .short_press(short_press), .double_click(double_click),
        .long_press(long_press), .auto_repeat(auto_repeat), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 short, 1 double, 2 long, 3 repeat
        int cyc;
    } ev_t;

    ev_t  sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] mon_v;
    ev_t  mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        mon_v = {auto_repeat, long_press, double_click, short_press};
        if (!rst && mon_v != 4'b0) begin
            checks++;
            assert ($countones(mon_v) == 1) else begin
                failures++;
                $error("FAIL onehot cyc=%0d observed=%b expected=one bit", cyc, mon_v);
            end
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_pulse cyc=%0d observed=%b expected=none", cyc, mon_v);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checks++;
                assert (mon_v === (4'b0001 << mon_e.kind) && cyc === mon_e.cyc) else begin
                    failures++;
                    $error("FAIL pulse observed=%b@%0d expected=%b@%0d",
                           mon_v, cyc, 4'b0001 << mon_e.kind, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse(input logic p, input logic r, input int n);
        goto(n);
        key_press   = p;
        key_release = r;
        @(negedge clk);
        key_press   = 1'b0;
        key_release = 1'b0;
    endtask

    task automatic expect_ev(input int kind, input int c);
        sb.push_back('{kind, c});
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, rel, lp, t, p2;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {28'b0, short_press, double_click, long_press, auto_repeat}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Short press
        b = cyc + 10;
        pulse(1, 0, b);
        goto(b + 1);
        chk("short_busy_hi", busy, 1);
        rel = b + 2000;
        expect_ev(0, rel + DBL_MS * P + 2);
        pulse(0, 1, rel);
        goto(rel + DBL_MS * P + 1);
        chk("short_busy_pre", busy, 1);
        goto(rel + DBL_MS * P + 2);
        chk("short_busy_lo", busy, 0);
        goto(cyc + 20);
        chk("short_sb_empty", sb.size(), 0);

        // Double click, with an ignored third press while in PRESS2
        b = cyc + 10;
        pulse(1, 0, b);
        pulse(0, 1, b + 2000);
        pulse(1, 0, b + 3990);
        pulse(1, 0, b + 4500);
        expect_ev(1, b + 5001);
        pulse(0, 1, b + 5000);
        goto(b + 5001);
        chk("dbl_busy_lo", busy, 0);
        goto(b + 5200);
        chk("dbl_sb_empty", sb.size(), 0);

        // Long press followed by auto-repeat; release is silent
        b = cyc + 10;
        lp = b + LONG_MS * P + 2;
        rel = b + 19990;
        expect_ev(2, lp);
        for (t = lp + R_GAP; t <= rel; t += R_GAP) expect_ev(3, t);
        pulse(1, 0, b);
        pulse(0, 1, rel);
        goto(rel + 1);
        chk("long_busy_lo", busy, 0);
        goto(rel + DBL_MS * P + 20);
        chk("long_sb_empty", sb.size(), 0);

        // Release on the exact cycle the long condition is met
        b = cyc + 10;
        rel = b + 1 + LONG_MS * P;
        expect_ev(0, rel + DBL_MS * P + 2);
        pulse(1, 0, b);
        pulse(0, 1, rel);
        goto(rel + DBL_MS * P + 20);
        chk("bnd_long_sb_empty", sb.size(), 0);

        // Second press on the exact cycle the double-click window expires
        b = cyc + 10;
        pulse(1, 0, b);
        pulse(0, 1, b + 100);
        p2 = b + 100 + 1 + DBL_MS * P;
        pulse(1, 0, p2);
        goto(p2 + 1);
        chk("bnd_dbl_busy", busy, 1);
        expect_ev(1, p2 + 51);
        pulse(0, 1, p2 + 50);
        goto(p2 + 51 + DBL_MS * P + 10);
        chk("bnd_dbl_sb_empty", sb.size(), 0);

        // Simultaneous press+release, then lone release, in IDLE
        b = cyc + 10;
        pulse(1, 1, b);
        goto(b + 2);
        chk("simul_busy", busy, 0);
        pulse(0, 1, b + 5);
        goto(b + 7);
        chk("lone_rel_busy", busy, 0);
        goto(b + 50);
        chk("spurious_sb_empty", sb.size(), 0);

        // Async reset in HOLD between repeats
        b = cyc + 10;
        lp = b + LONG_MS * P + 2;
        expect_ev(2, lp);
        expect_ev(3, lp + R_GAP);
        pulse(1, 0, b);
        goto(lp + R_GAP + 1500);
        chk("hold_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_outs", {28'b0, short_press, double_click, long_press, auto_repeat}, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        goto(cyc + 4000);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_sb_empty", sb.size(), 0);
        b = cyc + 10;
        pulse(1, 0, b);
        goto(b + 1);
        chk("fresh_busy", busy, 1);
        rel = b + 100;
        expect_ev(0, rel + DBL_MS * P + 2);
        pulse(0, 1, rel);
        goto(rel + DBL_MS * P + 20);
        chk("fresh_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
